// File: rtl/closest_pos_scanner_if.sv
// Board-side bus of the move selector: turn code and board image in, selected cell
// address and write strobe out, plus status flags.
interface closest_pos_scanner_if #(
  parameter int unsigned N = 3
) ();
  localparam int unsigned ADDR_W = $clog2(N * N + 1);

  logic [1:0]       cell_state;
  logic [2*N*N-1:0] g_board;
  logic [ADDR_W-1:0] addr;
  logic             write_to_board;
  logic             busy;
  logic             board_full;

  // Controller / board side
  modport master (
    output cell_state,
    output g_board,
    input  addr,
    input  write_to_board,
    input  busy,
    input  board_full
  );

  // Scanner side
  modport slave (
    input  cell_state,
    input  g_board,
    output addr,
    output write_to_board,
    output busy,
    output board_full
  );
endinterface

// File: rtl/closest_pos_scanner.sv
// AI move selector for an N x N tic-tac-toe board. On the AI's turn it walks the board
// one row per cycle, picks the first empty cell in scan order and pulses a single write
// strobe carrying that cell's address. A board with no empty cell parks in a sticky FULL
// state until reset.
// Optional feature: define CLOSEST_POS_CENTER_FIRST_EN to try the centre cell in the first
// scan cycle (odd N only) before falling back to the row scan.
// The bus interface must be instantiated with the same N as this module.
module closest_pos_scanner #(
  parameter int unsigned N        = 3,
  parameter logic [1:0]  AI_CODE  = 2'b10,
  parameter bit          SCAN_REV = 1'b0
) (
  input  logic                 ph1,
  input  logic                 reset,
  closest_pos_scanner_if.slave bus
);

  localparam int unsigned AddrW = $clog2(N * N + 1);
  localparam int unsigned RowW  = (N > 1) ? $clog2(N) : 1;

  localparam logic [RowW-1:0] FirstRow = SCAN_REV ? '0 + RowW'(N - 1) : '0;
  localparam logic [RowW-1:0] LastRow  = SCAN_REV ? '0 : RowW'(N - 1);

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StWrite,
    StHold,
    StFull
  } state_e;

  state_e            state_q;
  logic [RowW-1:0]   row_q;
  logic [AddrW-1:0]  addr_q;
  logic              wr_q;
  logic              busy_q;
  logic              full_q;

  logic              turn;
  logic              row_hit;
  int unsigned       hit_idx;
  int unsigned       cell_idx;
  logic [AddrW-1:0]  hit_addr;

  logic              center_now;
  logic              center_free;
  logic [AddrW-1:0]  center_addr;

  assign turn = (bus.cell_state == AI_CODE);

  // First empty cell of the current row in scan order. Columns are visited in reverse
  // scan order so the last hit written is the first one the scan would meet.
  always_comb begin
    row_hit  = 1'b0;
    hit_idx  = 0;
    cell_idx = 0;
    for (int unsigned k = 0; k < N; k++) begin
      cell_idx = 32'(row_q) * N + (SCAN_REV ? k : (N - 1 - k));
      if (bus.g_board[2*cell_idx +: 2] == 2'b00) begin
        row_hit = 1'b1;
        hit_idx = cell_idx;
      end
    end
  end

  assign hit_addr = AddrW'(hit_idx);

`ifdef CLOSEST_POS_CENTER_FIRST_EN
  localparam bit          CenterEn  = (N % 2) == 1;
  localparam int unsigned CenterIdx = (N * N - 1) / 2;

  logic center_q;

  // Centre probe is armed while idle and consumed by the first scan cycle.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      center_q <= 1'b0;
    end else if (state_q == StIdle) begin
      center_q <= CenterEn;
    end else begin
      center_q <= 1'b0;
    end
  end

  assign center_now  = center_q;
  assign center_free = (bus.g_board[2*CenterIdx +: 2] == 2'b00);
  assign center_addr = AddrW'(CenterIdx);
`else
  assign center_now  = 1'b0;
  assign center_free = 1'b0;
  assign center_addr = '0;
`endif

  // Selector FSM with all outputs registered alongside the state.
  always_ff @(posedge ph1) begin
    if (!reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (turn) begin
            state_q <= StScan;
            row_q   <= FirstRow;
            busy_q  <= 1'b1;
          end
        end
        StScan: begin
          if (!turn) begin
            // Turn withdrawn mid-scan: abandon without touching addr.
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (center_now) begin
            // Occupied centre simply falls through to row scan next cycle.
            if (center_free) begin
              addr_q  <= center_addr;
              wr_q    <= 1'b1;
              state_q <= StWrite;
            end
          end else if (row_hit) begin
            addr_q  <= hit_addr;
            wr_q    <= 1'b1;
            state_q <= StWrite;
          end else if (row_q == LastRow) begin
            addr_q  <= '1;
            full_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StFull;
          end else begin
            row_q <= SCAN_REV ? (row_q - 1'b1) : (row_q + 1'b1);
          end
        end
        StWrite: begin
          state_q <= StHold;
        end
        StHold: begin
          // Wait for the controller to drop the turn so each turn writes once.
          if (!turn) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end
        end
        StFull: begin
          state_q <= StFull;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.addr           = addr_q;
  assign bus.write_to_board = wr_q;
  assign bus.busy           = busy_q;
  assign bus.board_full     = full_q;

endmodule
